// File: rtl/updn_mod_counter.sv
// Synchronous up/down modulo counter with parallel load, wrap-or-saturate ends,
// a registered wrap pulse and a combinational terminal-count decode for cascading.
module updn_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  // Range ends jump straight to 0 or MAX_Q, so unused codes above MAX_Q are never visited.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          q_next = q + ONE;
        end else if (!SATURATE) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_next = q - ONE;
        end else if (!SATURATE) begin
          q_next    = MAX_Q;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

  assign tc = (up_dn & at_max) | (~up_dn & at_zero);

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed self-checking bench: mod-10 wrap and saturate counters, an 8-bit
// full-range counter and a mod-2 counter for back-to-back wraps.
module tb_updn_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] d;
  logic [7:0] d_w;
  logic [1:0] d_b;

  logic [3:0] q_a, q_s;
  logic [7:0] q_w;
  logic [1:0] q_b;
  logic       tc_a, tc_s, tc_w, tc_b;
  logic       wrap_a, wrap_s, wrap_w, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updn_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q_a), .tc(tc_a), .wrap(wrap_a));

  updn_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q_s), .tc(tc_s), .wrap(wrap_s));

  updn_mod_counter #(.WIDTH(8)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d_w),
    .q(q_w), .tc(tc_w), .wrap(wrap_w));

  updn_mod_counter #(.WIDTH(2), .MAX_COUNT(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; load = 1'b1; d = 4'd5; d_w = 8'd5; d_b = 2'd1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q_a !== 4'd0) begin
        errors++; $display("[TB] FAIL reset_q cycle %0d: got %0d, expected 0", i, q_a);
      end
      checks++;
      if (wrap_a !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_wrap cycle %0d: got %b, expected 0", i, wrap_a);
      end
    end
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (q_a !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_release_q: got %0d, expected 0", q_a);
    end
    checks++;
    if (tc_a !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_tc: got %b, expected 1", tc_a);
    end
  endtask

  task automatic test_down_wrap();
    int exp_q [12];
    logic exp_wrap;
    int prev;
    exp_q = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    rst = 1'b0; tick();
    rst = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b0;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_wrap = (prev == 0);
      checks++;
      if (q_a !== 4'(exp_q[i])) begin
        errors++; $display("[TB] FAIL down_q step %0d: got %0d, expected %0d", i, q_a, exp_q[i]);
      end
      checks++;
      if (wrap_a !== exp_wrap) begin
        errors++; $display("[TB] FAIL down_wrap step %0d: got %b, expected %b", i, wrap_a, exp_wrap);
      end
      checks++;
      if (tc_a !== (exp_q[i] == 0)) begin
        errors++; $display("[TB] FAIL down_tc step %0d: got %b, expected %b", i, tc_a, exp_q[i] == 0);
      end
      prev = exp_q[i];
    end
  endtask

  task automatic test_up_wrap();
    int exp_q [4];
    exp_q = '{8, 9, 0, 1};
    en = 1'b0; load = 1'b1; d = 4'd7; up_dn = 1'b1;
    tick();
    checks++;
    if (q_a !== 4'd7) begin
      errors++; $display("[TB] FAIL up_load_q: got %0d, expected 7", q_a);
    end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q_a !== 4'(exp_q[i])) begin
        errors++; $display("[TB] FAIL up_q step %0d: got %0d, expected %0d", i, q_a, exp_q[i]);
      end
      checks++;
      if (wrap_a !== (exp_q[i] == 0)) begin
        errors++; $display("[TB] FAIL up_wrap step %0d: got %b, expected %b", i, wrap_a, exp_q[i] == 0);
      end
      checks++;
      if (tc_a !== (exp_q[i] == 9)) begin
        errors++; $display("[TB] FAIL up_tc step %0d: got %b, expected %b", i, tc_a, exp_q[i] == 9);
      end
    end
  endtask

  task automatic test_load_priority();
    en = 1'b0; load = 1'b1; d = 4'd3; up_dn = 1'b1;
    tick();
    en = 1'b1; d = 4'd6;
    tick();
    checks++;
    if (q_a !== 4'd6 || wrap_a !== 1'b0) begin
      errors++; $display("[TB] FAIL load_over_en: got q=%0d wrap=%b, expected q=6 wrap=0", q_a, wrap_a);
    end
    d = 4'd13;
    tick();
    checks++;
    if (q_a !== 4'd9) begin
      errors++; $display("[TB] FAIL load_clamp: got %0d, expected 9", q_a);
    end
    // q sits at MAX with en high and up: the load must suppress the wrap.
    d = 4'd9;
    tick();
    checks++;
    if (q_a !== 4'd9 || wrap_a !== 1'b0) begin
      errors++; $display("[TB] FAIL load_at_wrap: got q=%0d wrap=%b, expected q=9 wrap=0", q_a, wrap_a);
    end
    rst = 1'b0; d = 4'd5;
    tick();
    checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_over_load: got q=%0d wrap=%b, expected q=0 wrap=0", q_a, wrap_a);
    end
    rst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_q;
    en = 1'b0; load = 1'b1; d = 4'd1;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q_s !== 4'd0 || wrap_s !== 1'b0 || tc_s !== 1'b1) begin
        errors++; $display("[TB] FAIL sat_down step %0d: got q=%0d wrap=%b tc=%b, expected q=0 wrap=0 tc=1",
                           i, q_s, wrap_s, tc_s);
      end
    end
    up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_q = (i < 9) ? i + 1 : 9;
      checks++;
      if (q_s !== 4'(exp_q) || wrap_s !== 1'b0) begin
        errors++; $display("[TB] FAIL sat_up step %0d: got q=%0d wrap=%b, expected q=%0d wrap=0",
                           i, q_s, wrap_s, exp_q);
      end
      checks++;
      if (tc_s !== (exp_q == 9)) begin
        errors++; $display("[TB] FAIL sat_up_tc step %0d: got %b, expected %b", i, tc_s, exp_q == 9);
      end
    end
  endtask

  task automatic test_hold_flip();
    int exp_q [4];
    exp_q = '{5, 4, 5, 4};
    en = 1'b0; load = 1'b1; d = 4'd4;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q_a !== 4'd4 || wrap_a !== 1'b0) begin
        errors++; $display("[TB] FAIL hold step %0d: got q=%0d wrap=%b, expected q=4 wrap=0", i, q_a, wrap_a);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      checks++;
      if (q_a !== 4'(exp_q[i])) begin
        errors++; $display("[TB] FAIL flip step %0d: got %0d, expected %0d", i, q_a, exp_q[i]);
      end
    end
    en = 1'b0; load = 1'b1; d = 4'd0;
    tick();
    load = 1'b0; up_dn = 1'b0;
    #1;
    checks++;
    if (tc_a !== 1'b1) begin
      errors++; $display("[TB] FAIL tc_comb_down: got %b, expected 1", tc_a);
    end
    up_dn = 1'b1;
    #1;
    checks++;
    if (tc_a !== 1'b0) begin
      errors++; $display("[TB] FAIL tc_comb_up: got %b, expected 0", tc_a);
    end
  endtask

  task automatic test_full_width();
    en = 1'b0; load = 1'b1; d_w = 8'd254; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q_w !== 8'd255 || wrap_w !== 1'b0 || tc_w !== 1'b1) begin
      errors++; $display("[TB] FAIL w8_max: got q=%0d wrap=%b tc=%b, expected q=255 wrap=0 tc=1", q_w, wrap_w, tc_w);
    end
    tick();
    checks++;
    if (q_w !== 8'd0 || wrap_w !== 1'b1) begin
      errors++; $display("[TB] FAIL w8_wrap: got q=%0d wrap=%b, expected q=0 wrap=1", q_w, wrap_w);
    end
    tick();
    checks++;
    if (q_w !== 8'd1 || wrap_w !== 1'b0) begin
      errors++; $display("[TB] FAIL w8_after: got q=%0d wrap=%b, expected q=1 wrap=0", q_w, wrap_w);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_q [4];
    exp_q = '{0, 1, 0, 1};
    en = 1'b0; load = 1'b1; d_b = 2'd3;
    tick();
    checks++;
    if (q_b !== 2'd1) begin
      errors++; $display("[TB] FAIL b2b_clamp: got %0d, expected 1", q_b);
    end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      checks++;
      if (q_b !== 2'(exp_q[i]) || wrap_b !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b step %0d: got q=%0d wrap=%b, expected q=%0d wrap=1",
                           i, q_b, wrap_b, exp_q[i]);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (wrap_b !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_end: got %b, expected 0", wrap_b);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0;
    d = '0; d_w = '0; d_b = '0;
    #2;
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_load_priority();
    test_saturate();
    test_hold_flip();
    test_full_width();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
